// File: rtl/flp_fif_vr.sv
// Flop-output FIFO with valid/ready on both sides, flush, af/ae thresholds and a high-water mark.
// Optional even-parity protection of stored entries is enabled by defining FLP_FIF_VR_PAR_EN.
module flp_fif_vr #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THR     = DEPTH - 2,
    parameter int AE_THR     = 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  in_rdy,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_dat,
    input  logic                  out_rdy,
    input  logic                  flush,
    input  logic                  hwm_clr,
    output logic [ADDR_WIDTH:0]   cnt,
    output logic                  af,
    output logic                  ae,
    output logic [ADDR_WIDTH:0]   hwm,
    output logic                  par_err
);

    localparam int BODY_N = DEPTH - 1;
`ifdef FLP_FIF_VR_PAR_EN
    localparam int SW = DATA_WIDTH + 1;
`else
    localparam int SW = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0]   FULL     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE      = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   AF_C     = (ADDR_WIDTH + 1)'(AF_THR);
    localparam logic [ADDR_WIDTH:0]   AE_C     = (ADDR_WIDTH + 1)'(AE_THR);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 2);

    logic [SW-1:0]         head_q;
    logic [SW-1:0]         body_q [BODY_N];
    logic [SW-1:0]         in_word;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_nxt, hwm_q, hwm_nxt;
    logic                  push, pop;
    logic                  head_ld_in, head_ld_body, body_wr;
    logic [BODY_N-1:0]     body_we;

    assign in_rdy  = (cnt_q != FULL);
    assign out_vld = (cnt_q != '0);
    assign out_dat = head_q[DATA_WIDTH-1:0];
    assign cnt     = cnt_q;
    assign hwm     = hwm_q;
    assign af      = (cnt_q >= AF_C);
    assign ae      = (cnt_q <= AE_C);

`ifdef FLP_FIF_VR_PAR_EN
    logic par_err_q;
    assign in_word = {^in_dat, in_dat};
    assign par_err = par_err_q;
`else
    assign in_word = in_dat;
    assign par_err = 1'b0;
`endif

    // Flush gates the handshakes so a same-cycle transfer touches no storage.
    always_comb begin
        push         = in_vld & in_rdy & ~flush;
        pop          = out_vld & out_rdy & ~flush;
        head_ld_in   = push & ((cnt_q == '0) | (pop & (cnt_q == ONE)));
        head_ld_body = pop & (cnt_q > ONE);
        body_wr      = push & ~head_ld_in;
        body_we      = '0;
        for (int unsigned i = 0; i < BODY_N; i++) begin
            body_we[i] = body_wr & (wr_ptr == ADDR_WIDTH'(i));
        end

        if (flush) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(pop);
        end

        if (hwm_clr) begin
            hwm_nxt = cnt_nxt;
        end else begin
            hwm_nxt = (cnt_nxt > hwm_q) ? cnt_nxt : hwm_q;
        end

        wr_nxt = wr_ptr;
        rd_nxt = rd_ptr;
        if (body_wr) begin
            wr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end
        if (head_ld_body) begin
            rd_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        end
        // With at most the head occupied the body is empty, so realign both pointers.
        if (cnt_nxt <= ONE) begin
            wr_nxt = '0;
            rd_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            hwm_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            cnt_q  <= cnt_nxt;
            hwm_q  <= hwm_nxt;
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
        end
    end

`ifdef FLP_FIF_VR_PAR_EN
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            par_err_q <= 1'b0;
        end else if (out_vld && (^head_q)) begin
            par_err_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (head_ld_in) begin
            head_q <= in_word;
        end else if (head_ld_body) begin
            head_q <= body_q[rd_ptr];
        end
        for (int unsigned i = 0; i < BODY_N; i++) begin
            if (body_we[i]) begin
                body_q[i] <= in_word;
            end
        end
    end

    a_body_we_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(body_we));
    a_cnt_range:       assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= FULL);
    a_single_input:    assert property (@(posedge clk) disable iff (!rst_n) !(head_ld_in && body_wr));

endmodule

// File: tb/tb_flp_fif_vr.sv
// Directed table-driven bench for flp_fif_vr (DEPTH=8), plus scoreboarded sequences
// for pointer wrap and the parity error flag.
module tb_flp_fif_vr;

    logic       clk = 1'b0;
    logic       rst_n, in_vld, out_rdy, flush, hwm_clr;
    logic [7:0] in_dat;
    logic       in_rdy, out_vld, af, ae, par_err;
    logic [7:0] out_dat;
    logic [3:0] cnt, hwm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    flp_fif_vr #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_dat(out_dat), .out_rdy(out_rdy), .flush(flush),
        .hwm_clr(hwm_clr), .cnt(cnt), .af(af), .ae(ae), .hwm(hwm), .par_err(par_err)
    );

    typedef struct {
        logic       r, v;
        logic [7:0] d;
        logic       o, fl, hc;
        int         ecnt;
        logic [7:0] edat;
        int         ehwm;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic o,
                       input logic fl, input logic hc, input int c, input logic [7:0] ed,
                       input int h);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.o = o; x.fl = fl; x.hc = hc;
        x.ecnt = c; x.edat = ed; x.ehwm = h;
        tv.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] d;
        logic       pv, pr;

        rst_n = 1'b0; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0; flush = 1'b0; hwm_clr = 1'b0;

        //  r  v  d      o  fl hc cnt edat   hwm
        add(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) add(1, 1, 8'h11 + 8'(i), 0, 0, 0, i + 1, 8'h11, i + 1);
        for (int i = 0; i < 8; i++) add(1, 0, 8'h00, 1, 0, 0, 7 - i, 8'h12 + 8'(i), 8);
        add(1, 1, 8'hA5, 0, 0, 0, 1, 8'hA5, 8);
        add(1, 1, 8'h5A, 1, 0, 0, 1, 8'h5A, 8);
        add(1, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) add(1, 1, 8'h21 + 8'(i), 0, 0, 0, i + 1, 8'h21, i + 1);
        add(1, 1, 8'h99, 1, 1, 0, 0, 8'h00, 6);
        add(1, 1, 8'h33, 0, 0, 0, 1, 8'h33, 6);
        for (int i = 0; i < 6; i++) add(1, 1, 8'h41 + 8'(i), 0, 0, 0, i + 2, 8'h33, (i == 5) ? 7 : 6);
        for (int i = 0; i < 5; i++) add(1, 0, 8'h00, 1, 0, 0, 6 - i, 8'h41 + 8'(i), 7);
        add(1, 0, 8'h00, 0, 0, 1, 2, 8'h45, 2);
        add(1, 1, 8'h51, 0, 0, 0, 3, 8'h45, 3);
        add(1, 1, 8'h52, 0, 0, 0, 4, 8'h45, 4);
        add(0, 1, 8'h53, 0, 0, 0, 0, 8'h00, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

        for (int i = 0; i < tv.size(); i++) begin
            rst_n = tv[i].r; in_vld = tv[i].v; in_dat = tv[i].d;
            out_rdy = tv[i].o; flush = tv[i].fl; hwm_clr = tv[i].hc;
            tick();
            chk($sformatf("v%0d cnt", i), int'(cnt), tv[i].ecnt);
            chk($sformatf("v%0d out_vld", i), int'(out_vld), int'(tv[i].ecnt != 0));
            chk($sformatf("v%0d in_rdy", i), int'(in_rdy), int'(tv[i].ecnt != 8));
            chk($sformatf("v%0d af", i), int'(af), int'(tv[i].ecnt >= 6));
            chk($sformatf("v%0d ae", i), int'(ae), int'(tv[i].ecnt <= 1));
            chk($sformatf("v%0d hwm", i), int'(hwm), tv[i].ehwm);
            chk($sformatf("v%0d par_err", i), int'(par_err), 0);
            if (tv[i].ecnt != 0) chk($sformatf("v%0d out_dat", i), int'(out_dat), int'(tv[i].edat));
        end

        // Pre-fill to 4, then keep occupancy within 3..5 while traffic wraps the ring.
        rst_n = 1'b1; flush = 1'b0; hwm_clr = 1'b0; out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            in_vld = 1'b1; in_dat = d;
            tick();
            q.push_back(d);
        end
        for (int i = 0; i < 40; i++) begin
            pv = ($urandom_range(0, 3) != 0);
            pr = ($urandom_range(0, 3) != 0);
            if (q.size() == 5 && pv && !pr) pv = 1'b0;
            if (q.size() == 3 && pr && !pv) pr = 1'b0;
            d = 8'($urandom);
            in_vld = pv; in_dat = d; out_rdy = pr;
            tick();
            if (pr) void'(q.pop_front());
            if (pv) q.push_back(d);
            chk($sformatf("rnd%0d cnt", i), int'(cnt), q.size());
            chk($sformatf("rnd%0d out_dat", i), int'(out_dat), int'(q[0]));
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            tick();
            void'(q.pop_front());
            chk($sformatf("drain%0d cnt", i), int'(cnt), q.size());
            if (q.size() > 0) chk($sformatf("drain%0d out_dat", i), int'(out_dat), int'(q[0]));
        end
        chk("drain out_vld", int'(out_vld), 0);

        out_rdy = 1'b0;
        in_vld = 1'b1; in_dat = 8'h77;
        tick();
        in_vld = 1'b0;
        chk("par head", int'(out_dat), 8'h77);
`ifdef FLP_FIF_VR_PAR_EN
        force dut.head_q = 9'h076;
        tick();
        chk("par set", int'(par_err), 1);
        release dut.head_q;
        tick();
        chk("par hold", int'(par_err), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("par flush", int'(par_err), 0);
        chk("par flush cnt", int'(cnt), 0);
`else
        tick();
        chk("par off", int'(par_err), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flp_fif_vr.md
Name: flp_fif_vr

Overview:
Next-generation flop-output FIFO. Read data always comes from a dedicated head register, and the read mux sits behind that register, so the output path has no mux. It adds valid/ready handshakes on both sides, synchronous flush, almost-full/almost-empty thresholds and a clearable high-water mark. It is intended as the general buffering primitive between pipeline stages that need a registered output.

Parameters:
DATA_WIDTH, 8, payload width in bits.
DEPTH, 8, total entries (1 head + DEPTH-1 body); legal range DEPTH >= 2.
AF_THR, DEPTH-2, almost-full threshold; af asserts when cnt >= AF_THR.
AE_THR, 1, almost-empty threshold; ae asserts when cnt <= AE_THR.
ADDR_WIDTH, $clog2(DEPTH), derived; do not override.

Ports:
clk  in  1  clock; all state is updated on posedge.
rst_n  in  1  synchronous reset, active-low.
in_vld  in  1  write request.
in_dat  in  DATA_WIDTH  write data.
in_rdy  out  1  FIFO can accept; equals (cnt != DEPTH).
out_vld  out  1  head entry holds valid data; equals (cnt != 0).
out_dat  out  DATA_WIDTH  head register contents.
out_rdy  in  1  consumer accepts head.
flush  in  1  synchronous clear of contents.
hwm_clr  in  1  clear high-water mark.
cnt  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
af  out  1  almost full.
ae  out  1  almost empty.
hwm  out  ADDR_WIDTH+1  peak cnt since last reset or hwm_clr.
par_err  out  1  sticky parity error (see Optional Feature).

Behaviour:
- Reset values (rst_n=0 at posedge): cnt=0, hwm=0, par_err=0, head/body pointers=0. Head and body data are not reset. Outputs after reset: out_vld=0, in_rdy=1, af=(AF_THR==0), ae=1.
- push = in_vld & in_rdy; pop = out_vld & out_rdy.
- cnt_next = cnt + push - pop, computed at ADDR_WIDTH+1 bits with no wrap.
- in_rdy depends only on registered cnt. There is no combinational path from out_rdy to in_rdy. A push with cnt==DEPTH is impossible by construction, even when a pop occurs in the same cycle.
- Head register write rules (head written at most once per cycle):
  - push & (cnt==0): head <= in_dat.
  - push & pop & (cnt==1): head <= in_dat.
  - pop & (cnt>1): head <= body[rd_ptr].
- Body ring (DEPTH-1 entries):
  - Body write at wr_ptr on push whenever the head-load-from-input cases above do not apply.
  - rd_ptr advances on pop with cnt>1.
  - Both pointers wrap from DEPTH-2 to 0.
  - When cnt_next <= 1, both pointers return to 0.
- Latency: data pushed into an empty FIFO is visible on out_dat with out_vld=1 on the next cycle. Ordering is strict FIFO.
- Simultaneous push and pop at cnt==DEPTH cannot occur (in_rdy=0). At other counts, cnt is unchanged and ordering is preserved.
- flush (rst_n=1):
  - Next cycle: cnt=0, pointers=0, par_err=0.
  - A push or pop in the same cycle as flush is discarded.
  - hwm is unaffected.
- hwm:
  - Each cycle, hwm <= max(hwm, cnt_next).
  - On hwm_clr, hwm <= cnt_next.
  - rst_n takes priority over flush, and flush over normal operation.
- af and ae are combinational compares on registered cnt.
- Assertions, disabled during reset:
  - body write enables are onehot0;
  - cnt <= DEPTH;
  - head and body never take input data in the same cycle.

Optional Feature:
Macro FLP_FIF_VR_PAR_EN.
- Defined:
  - Each entry (head and body) stores DATA_WIDTH+1 bits: data plus even parity generated from in_dat.
  - Parity moves with the data into the head register.
  - par_err is set on any cycle where out_vld=1 and the head parity mismatches.
  - par_err stays set until rst_n or flush.
- Not defined: storage is DATA_WIDTH bits, no parity logic is generated, and par_err is tied 0.

Test Plan:
1. DEPTH=8. Reset, push 0x11..0x18 on consecutive cycles with out_rdy=0 -> cnt=8, in_rdy=0, af=1, out_dat=0x11. Then out_rdy=1 for 8 cycles -> 0x11..0x18 in order, cnt=0, ae=1, out_vld=0.
2. Empty FIFO, push 0xA5 -> out_vld=1 with out_dat=0xA5 next cycle. With cnt=1, push 0x5A and pop together -> next cycle out_dat=0x5A, cnt=1.
3. Hold cnt between 3 and 5 with random push/pop for 40 cycles, so pointers wrap at least twice -> scoreboard order match and no data loss.
4. cnt=6, assert flush together with in_vld=1 -> next cycle cnt=0, out_vld=0, hwm=6. Then push 0x33 -> out_dat=0x33, cnt=1.
5. Fill to cnt=7, drain to 2, pulse hwm_clr -> hwm=2 next cycle. Drive rst_n=0 for one cycle while cnt=4 -> cnt=0, hwm=0, in_rdy=1.
6. With FLP_FIF_VR_PAR_EN defined, force a flipped bit in the head register -> par_err=1 on the next cycle and held until flush. Without the macro -> par_err stays 0.
